// File: rtl/spart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, parity
// mode encodings, the buffered entry layout and a 3-sample majority vote.
package spart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Sized for the widest legal frame; narrower frames zero-extend.
    localparam int MAX_DATA_BITS = 9;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     frame_err;
        logic                     parity_err;
    } rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// Small synchronous FIFO; head entry is presented on dout_o, and a write
// into a full FIFO is accepted only when a read happens in the same cycle.
module spart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd) cnt_d = cnt_q + 1'b1;
        else if (do_rd && !do_wr) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/receive_os.sv
// Oversampling UART receiver with majority-vote bit sampling and a receive
// buffer: a FIFO when SPART_RX_FIFO_EN is defined, else one holding register.
module receive_os
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 baud_tick,
    input  logic [1:0]           parity_mode,
    input  logic                 receive_read_en,
    output logic                 rda,
    output logic [DATA_BITS-1:0] receive_read_line,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 receive_start
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE/2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE/2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    rx_state_t            state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic                 s0_q, s1_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [1:0]           pmode_q;
    logic                 par_err_q, need_high_q, wr_q, start_q, ovr_q;
    rx_entry_t            wr_ent_q, head;
    logic                 rx_s, maj, par_en, par_exp, avail, pop, drop;

    assign rx_s    = sync_q[1];
    assign maj     = majority3(s0_q, s1_q, rx_s);
    assign par_en  = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
    assign par_exp = (pmode_q == PAR_ODD) ? ~^shreg_q : ^shreg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rxd};
    end

    // Votes land at T_S2; the first two samples are held from earlier ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            shreg_q     <= '0;
            pmode_q     <= PAR_NONE;
            par_err_q   <= 1'b0;
            need_high_q <= 1'b0;
            wr_q        <= 1'b0;
            start_q     <= 1'b0;
            wr_ent_q    <= '0;
        end else begin
            start_q <= 1'b0;
            wr_q    <= 1'b0;
            if (state_q == ST_IDLE) begin
                pmode_q <= parity_mode;
                tick_q  <= '0;
                if (baud_tick) begin
                    if (need_high_q) begin
                        if (rx_s) need_high_q <= 1'b0;
                    end else if (!rx_s) begin
                        state_q   <= ST_START;
                        bit_q     <= '0;
                        par_err_q <= 1'b0;
                    end
                end
            end else if (baud_tick) begin
                tick_q <= (tick_q == T_END) ? '0 : tick_q + 1'b1;
                if (tick_q == T_S0) s0_q <= rx_s;
                if (tick_q == T_S1) s1_q <= rx_s;
                unique case (state_q)
                    ST_START: begin
                        if (tick_q == T_S2) begin
                            if (maj) state_q <= ST_IDLE;
                            else     start_q <= 1'b1;
                        end else if (tick_q == T_END) begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (tick_q == T_S2) begin
                            shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                        end else if (tick_q == T_END) begin
                            if (bit_q == B_END) state_q <= par_en ? ST_PARITY : ST_STOP;
                            else                bit_q   <= bit_q + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (tick_q == T_S2)       par_err_q <= (maj != par_exp);
                        else if (tick_q == T_END) state_q   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (tick_q == T_S2) begin
                            state_q             <= ST_IDLE;
                            wr_q                <= 1'b1;
                            wr_ent_q.data       <= MAX_DATA_BITS'(shreg_q);
                            wr_ent_q.frame_err  <= ~maj;
                            wr_ent_q.parity_err <= par_err_q;
                            need_high_q         <= ~maj;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign pop = receive_read_en && avail;

`ifdef SPART_RX_FIFO_EN
    logic [$bits(rx_entry_t)-1:0] head_bits;
    logic                         fifo_full, fifo_empty;

    spart_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (wr_q),
        .rd_en_i (pop),
        .din_i   (wr_ent_q),
        .dout_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head  = rx_entry_t'(head_bits);
    assign avail = !fifo_empty;
    assign drop  = wr_q && fifo_full && !pop;
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;
    rx_entry_t hold_q;
    logic      rda_q;

    // Reading clears rda only; the last word stays visible on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            rda_q  <= 1'b0;
        end else if (wr_q && (!rda_q || pop)) begin
            hold_q <= wr_ent_q;
            rda_q  <= 1'b1;
        end else if (pop) begin
            rda_q  <= 1'b0;
        end
    end

    assign head  = hold_q;
    assign avail = rda_q;
    assign drop  = wr_q && rda_q && !pop;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovr_q <= 1'b0;
        else if (pop)  ovr_q <= 1'b0;
        else if (drop) ovr_q <= 1'b1;
    end

    logic unused_data_bits;
    assign unused_data_bits = ^head.data;

    assign rda               = avail;
    assign receive_read_line = head.data[DATA_BITS-1:0];
    assign frame_err         = head.frame_err;
    assign parity_err        = head.parity_err;
    assign overrun           = ovr_q;
    assign receive_start     = start_q;

endmodule

// File: doc/receive_os.md
RECEIVE_OS -- requirements
Module: receive_os

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, baud_tick strobes per bit; even, legal range 8..32.
REQ-003 Parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, at least 2.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rxd  in  1  serial input, asynchronous to clk, idle high.
REQ-007 baud_tick  in  1  one-clk strobe at OVERSAMPLE x bit rate.
REQ-008 parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled only in IDLE.
REQ-009 receive_read_en  in  1  consumer pops/acknowledges the current word.
REQ-010 rda  out  1  a received word is available.
REQ-011 receive_read_line  out  DATA_BITS  data of the current word, LSB = first bit received.
REQ-012 frame_err  out  1  the current word's stop bit sampled low.
REQ-013 parity_err  out  1  the current word failed its parity check.
REQ-014 overrun  out  1  sticky; a completed frame was dropped.
REQ-015 receive_start  out  1  one-clk pulse when a valid start bit is confirmed.

Function
REQ-016 rxd SHALL pass through a two-flop synchroniser preset to 1; all sampling uses the synchronised value.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all counters advance only on baud_tick.
REQ-018 IDLE->START SHALL occur on a baud_tick with synchronised rxd low; tick counter cleared.
REQ-019 Each bit SHALL be the majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit.
REQ-020 START SHALL return to IDLE if majority is 1 (glitch rejected, no receive_start); else pulse receive_start, go to DATA.
REQ-021 DATA SHALL shift DATA_BITS bits LSB first, then go to PARITY if parity enabled, else STOP.
REQ-022 PARITY SHALL compare the sampled bit against even/odd parity of data; mismatch sets the entry's parity_err.
REQ-023 STOP SHALL sample at mid-bit, set frame_err if 0, write the entry one clk later, and return to IDLE without waiting for the remaining half bit.
REQ-024 After a frame_err, IDLE SHALL require synchronised rxd high for one tick before accepting a new start.
REQ-025 Entry write while buffer full SHALL drop the new entry and set overrun; overrun clears only on receive_read_en with rda high.
REQ-026 receive_read_en with rda low SHALL have no effect; simultaneous write and read when full SHALL succeed without overrun.
REQ-027 Outputs SHALL be registered; a write makes rda high on the next clk.

Reset
REQ-028 Reset SHALL force state IDLE, synchroniser to 1, counters 0, buffer empty, and outputs to rda 0, receive_read_line 0, frame_err 0, parity_err 0, overrun 0, receive_start 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; no entry is written after release.

Configuration
REQ-030 Macro SPART_RX_FIFO_EN defined: FIFO_DEPTH-entry FIFO of {data, frame_err, parity_err}; rda = not empty; read_en pops; outputs show head entry.
REQ-031 Macro undefined: single holding register, FIFO_DEPTH ignored; read_en clears rda only; new entry while rda high is dropped with overrun.

Structure
REQ-032 Package spart_pkg SHALL hold the rx_state_t enum, the parity_mode encoding constants and the rx_entry_t struct.
REQ-033 FIFO SHALL be sub-module spart_fifo (parameters WIDTH, DEPTH), instantiated only under SPART_RX_FIFO_EN.

Verification
REQ-034 8N1, OS=16, send 0xA5 -> rda high, receive_read_line 0xA5, frame_err 0, parity_err 0; rda high one clk after stop mid-sample.
REQ-035 8E1, send 0x07 with parity bit 0 -> receive_read_line 0x07, parity_err 1; with parity bit 1 -> parity_err 0.
REQ-036 rxd low pulse of 4 ticks then high -> no receive_start, rda stays 0, FSM back in IDLE.
REQ-037 Stop bit forced 0 on 0x3C -> frame_err 1, data 0x3C; next frame accepted only after one high tick.
REQ-038 FIFO on, depth 4: send 5 frames with no reads -> first 4 read back in order, overrun 1 until first pop.
REQ-039 Assert rst_n low mid-DATA of 0x55 -> all outputs 0; next frame 0x12 received cleanly.
